// File: rtl/encoder_decoder_sdiv_seq.sv
// encoder_decoder_sdiv_seq: restoring signed divider recovering a 13b unsigned activation
// from a 23b signed product and its 10b signed weight, one quotient bit per clock.
module encoder_decoder_sdiv_seq #(
    parameter int DIVIDEND_WIDTH = 23,
    parameter int DIVISOR_WIDTH  = 10,
    parameter int QUOT_WIDTH     = 13
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      ap_start,
    output logic                      ap_ready,
    output logic                      ap_idle,
    output logic                      ap_done,
    input  logic [DIVIDEND_WIDTH-1:0] din0,
    input  logic [DIVISOR_WIDTH-1:0]  din1,
    output logic [QUOT_WIDTH-1:0]     dout,
    output logic                      div_by_zero,
    output logic                      sat
);
    localparam int DW = DIVIDEND_WIDTH;
    localparam int VW = DIVISOR_WIDTH;
    localparam int QW = QUOT_WIDTH;
    localparam int RW = VW + 1;
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          r_state;
    logic [DW-1:0]   r_num;
    logic [DW-1:0]   r_q;
    logic [VW-1:0]   r_den;
    logic [RW-1:0]   r_rem;
    logic [CW-1:0]   r_cnt;
    logic            r_sign;
    logic            r_dz;
    logic [QW-1:0]   r_dout;
    logic            r_div_by_zero;
    logic            r_sat;
    logic            r_done;

    logic [DW-1:0]   w_mag0;
    logic [VW-1:0]   w_mag1;
    logic [RW-1:0]   w_sh;
    logic [RW-1:0]   w_sub;
    logic            w_ge;
    logic            w_big;

    // Two's-complement negate; the most negative dividend maps to 2^(DW-1), which still fits.
    assign w_mag0 = din0[DW-1] ? ~din0 + DW'(1) : din0;
    assign w_mag1 = din1[VW-1] ? ~din1 + VW'(1) : din1;
    assign w_sh   = {r_rem[VW-1:0], r_num[DW-1]};
    assign w_sub  = w_sh - {1'b0, r_den};
    assign w_ge   = w_sh >= {1'b0, r_den};
    assign w_big  = |r_q[DW-1:QW];

    assign ap_idle     = r_state == IDLE;
    assign ap_ready    = ap_start && r_state == IDLE;
    assign ap_done     = r_done;
    assign dout        = r_dout;
    assign div_by_zero = r_div_by_zero;
    assign sat         = r_sat;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state       <= IDLE;
            r_num         <= '0;
            r_q           <= '0;
            r_den         <= '0;
            r_rem         <= '0;
            r_cnt         <= '0;
            r_sign        <= 1'b0;
            r_dz          <= 1'b0;
            r_dout        <= '0;
            r_div_by_zero <= 1'b0;
            r_sat         <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (ap_start) begin
                    r_state <= CALC;
                    r_num   <= w_mag0;
                    r_den   <= w_mag1;
                    r_rem   <= '0;
                    r_q     <= '0;
                    r_cnt   <= '0;
                    r_sign  <= din0[DW-1] ^ din1[VW-1];
                    r_dz    <= din1 == '0;
                end
                CALC: begin
                    r_num   <= r_num << 1;
                    r_rem   <= w_ge ? w_sub : w_sh;
                    r_q     <= {r_q[DW-2:0], w_ge};
                    r_cnt   <= r_cnt == CW'(DW-1) ? '0 : r_cnt + CW'(1);
                    r_state <= r_cnt == CW'(DW-1) ? FIX : CALC;
                end
                FIX: begin
                    r_div_by_zero <= r_dz;
                    r_dout        <= (r_dz || r_q == '0 || r_sign) ? '0 : w_big ? {QW{1'b1}} : r_q[QW-1:0];
                    r_sat         <= !r_dz && r_q != '0 && (r_sign || w_big);
                    r_done        <= 1'b1;
                    r_state       <= DONE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_encoder_decoder_sdiv_seq.sv
// tb_encoder_decoder_sdiv_seq: directed and randomized checks of the sequential divider
// against an integer-division reference model.
module tb_encoder_decoder_sdiv_seq;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_ready, ap_idle, ap_done;
    logic [22:0] din0 = '0;
    logic [9:0]  din1 = '0;
    logic [12:0] dout;
    logic        div_by_zero, sat;
    int          n_tests = 0;
    int          n_fail = 0;

    encoder_decoder_sdiv_seq dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_idle(ap_idle), .ap_done(ap_done), .din0(din0), .din1(din1), .dout(dout),
        .div_by_zero(div_by_zero), .sat(sat)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model(input int a, input int b, output int q, output int dz, output int s);
        int t;
        dz = 0;
        s = 0;
        if (b == 0) begin
            q = 0;
            dz = 1;
        end else begin
            t = a / b;
            if (t < 0) begin
                q = 0;
                s = 1;
            end else if (t > 8191) begin
                q = 8191;
                s = 1;
            end else q = t;
        end
    endtask

    task automatic check_result(input string tag, input int a, input int b);
        int q, dz, s;
        model(a, b, q, dz, s);
        check({tag, "_dout"}, int'(dout), q);
        check({tag, "_dz"}, int'(div_by_zero), dz);
        check({tag, "_sat"}, int'(sat), s);
    endtask

    task automatic run_op(input int a, input int b);
        int k;
        bit seen;
        @(negedge ap_clk);
        din0 = a[22:0];
        din1 = b[9:0];
        ap_start = 1'b1;
        #1 check("ready_accept", int'(ap_ready), 1);
        @(posedge ap_clk);
        #1 ap_start = 1'b0;
        din0 = 23'($urandom);
        din1 = 10'($urandom);
        k = 0;
        seen = 0;
        while (!seen && k < 40) begin
            @(negedge ap_clk);
            k++;
            seen = ap_done;
        end
        check("done_cycle", k, 25);
        check_result("op", a, b);
        @(negedge ap_clk);
        check("done_pulse", int'(ap_done), 0);
    endtask

    initial begin
        int a, b, q, r, mag, ib;
        #1 ap_rst_n = 1'b0;
        #1;
        check("rst_idle", int'(ap_idle), 1);
        check("rst_done", int'(ap_done), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_dz", int'(div_by_zero), 0);
        check("rst_sat", int'(sat), 0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;

        run_op(-18000, -3);
        run_op(4185601, 511);
        run_op(100, 7);
        run_op(-100, 7);
        run_op(4000000, 1);
        run_op(-5, 9);
        run_op(1234, 0);
        run_op(-4194304, -1);
        run_op(-4194304, 511);
        run_op(4194303, -512);
        run_op(8191, 1);

        din0 = 23'(3000);
        din1 = 10'(3);
        @(negedge ap_clk);
        ap_start = 1'b1;
        for (int k = 0; k < 78; k++) begin
            if (k > 0) @(negedge ap_clk);
            #1;
            check("cont_ready", int'(ap_ready), int'(k % 26 == 0));
            check("cont_done", int'(ap_done), int'(k % 26 == 25));
            if (k % 26 == 25) check_result("cont", 3000, 3);
        end
        ap_start = 1'b0;

        run_op(4000000, 1);
        @(negedge ap_clk);
        din0 = 23'(1000);
        din1 = 10'(3);
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1 ap_start = 1'b0;
        repeat (10) @(negedge ap_clk);
        #1 ap_rst_n = 1'b0;
        #1;
        check("abort_idle", int'(ap_idle), 1);
        check("abort_dout", int'(dout), 0);
        check("abort_sat", int'(sat), 0);
        check("abort_done", int'(ap_done), 0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge ap_clk);
            check("abort_no_done", int'(ap_done), 0);
        end
        run_op(1000, 3);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = int'($urandom) <<< 9 >>> 9;
                b = $urandom_range(0, 7) == 0 ? 0 : int'($urandom) <<< 22 >>> 22;
            end else begin
                b = int'($urandom) <<< 22 >>> 22;
                if (b == 0) b = 1;
                ib = b < 0 ? -b : b;
                q = $urandom_range(0, 8191);
                r = $urandom_range(0, ib - 1);
                mag = q * ib + r;
                a = $urandom_range(0, 3) == 0 ? -mag : mag;
            end
            run_op(a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
